// File: rtl/if_pc_stage.sv
// ---------------------------------------------------------------------------
// if_pc_stage
//   Instruction-fetch stage. Holds the program counter, presents it to
//   instruction memory, feeds PC+PC_INC back to the PC source mux and
//   captures the fetched instruction with its PC into the IF/ID register.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   newPC         next PC from the PC source mux (word-aligned on load)
//   stall         hold PC and IF/ID
//   flush         squash IF/ID and redirect PC to newPC (beats stall)
//   imem_data     instruction word from memory
//   imem_ready    imem_data valid for the current imem_addr
//   imem_req      fetch request (depends on state only)
//   imem_addr     fetch address (= PC)
//   currentPC     PC + PC_INC, wraps mod 2^32
//   IF_ID_PC      PC of the instruction in IF/ID
//   IF_ID_instr   instruction in IF/ID (NOP_INSTR on bubble/flush)
//   IF_ID_valid   IF/ID holds a real instruction
//
// Optional feature (macro IF_PERF_CNT_EN):
//   fetch_count   saturating count of accepted fetches
//   bubble_count  saturating count of flush/not-ready cycles in FETCH
// ---------------------------------------------------------------------------
module if_pc_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          PC_INC    = 4,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] newPC,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] imem_data,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] currentPC,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_instr,
`ifdef IF_PERF_CNT_EN
  output logic        IF_ID_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
`else
  output logic        IF_ID_valid
`endif
);

  localparam logic [31:0] PC_INC_W = 32'(PC_INC);

  typedef enum logic {BOOT, FETCH} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] if_id_pc_reg, if_id_pc_next;
  logic [31:0] if_id_instr_reg, if_id_instr_next;
  logic        if_id_valid_reg, if_id_valid_next;

  // Loaded PCs are always forced to a word boundary.
  logic [31:0] new_pc_aligned;
  assign new_pc_aligned = {newPC[31:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= BOOT;
      pc_reg          <= RESET_PC;
      if_id_pc_reg    <= 32'h0000_0000;
      if_id_instr_reg <= NOP_INSTR;
      if_id_valid_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      if_id_pc_reg    <= if_id_pc_next;
      if_id_instr_reg <= if_id_instr_next;
      if_id_valid_reg <= if_id_valid_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    if_id_pc_next    = if_id_pc_reg;
    if_id_instr_next = if_id_instr_reg;
    if_id_valid_next = if_id_valid_reg;
    case (state_reg)
      BOOT: begin
        state_next       = FETCH;
        if_id_valid_next = 1'b0;
      end
      FETCH: begin
        if (flush) begin
          // Redirect: whatever memory returned this cycle is dropped.
          pc_next          = new_pc_aligned;
          if_id_pc_next    = pc_reg;
          if_id_instr_next = NOP_INSTR;
          if_id_valid_next = 1'b0;
        end else if (stall) begin
          // Hold everything; the fetch of pc_reg simply repeats.
        end else if (imem_ready) begin
          pc_next          = new_pc_aligned;
          if_id_pc_next    = pc_reg;
          if_id_instr_next = imem_data;
          if_id_valid_next = 1'b1;
        end else begin
          // Memory not ready: insert a bubble and retry the same PC.
          if_id_pc_next    = pc_reg;
          if_id_instr_next = NOP_INSTR;
          if_id_valid_next = 1'b0;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  assign imem_req    = (state_reg == FETCH);
  assign imem_addr   = pc_reg;
  assign currentPC   = pc_reg + PC_INC_W;
  assign IF_ID_PC    = if_id_pc_reg;
  assign IF_ID_instr = if_id_instr_reg;
  assign IF_ID_valid = if_id_valid_reg;

`ifdef IF_PERF_CNT_EN
  // Index 0 counts accepted fetches, index 1 counts bubbles (flush or
  // not-ready). Stalled cycles count toward neither.
  logic [1:0] cnt_evt;
  assign cnt_evt[0] = (state_reg == FETCH) && !flush && !stall && imem_ready;
  assign cnt_evt[1] = (state_reg == FETCH) && (flush || (!stall && !imem_ready));

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_cnt
      logic [31:0] cnt_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          cnt_reg <= 32'h0000_0000;
        else if (cnt_evt[gi] && (cnt_reg != 32'hFFFF_FFFF))
          cnt_reg <= cnt_reg + 32'd1;
      end
    end
  endgenerate

  assign fetch_count  = gen_cnt[0].cnt_reg;
  assign bubble_count = gen_cnt[1].cnt_reg;
`endif

endmodule

// File: tb/tb_if_pc_stage.sv
module tb_if_pc_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] newPC;
  logic        stall;
  logic        flush;
  logic [31:0] imem_data;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] currentPC;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_instr;
  logic        IF_ID_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
`endif

  int checks = 0;
  int errors = 0;
  int exp_fetch = 0;
  int exp_bubble = 0;

  if_pc_stage #(
    .RESET_PC (32'h0000_0000),
    .PC_INC   (4),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .newPC      (newPC),
    .stall      (stall),
    .flush      (flush),
    .imem_data  (imem_data),
    .imem_ready (imem_ready),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .currentPC  (currentPC),
    .IF_ID_PC   (IF_ID_PC),
    .IF_ID_instr(IF_ID_instr),
`ifdef IF_PERF_CNT_EN
    .IF_ID_valid(IF_ID_valid),
    .fetch_count(fetch_count),
    .bubble_count(bubble_count)
`else
    .IF_ID_valid(IF_ID_valid)
`endif
  );

  always #5 clk = ~clk;

  // One FETCH-state clock: tally the expected counter events from the
  // inputs being applied, then sample 1 time unit after the edge.
  task automatic step();
    if (flush) exp_bubble++;
    else if (!stall) begin
      if (imem_ready) exp_fetch++;
      else exp_bubble++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; newPC = 0; stall = 0; flush = 0; imem_data = 0; imem_ready = 0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || IF_ID_valid !== 1'b0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: req=%b valid=%b addr=%h required 0/0/0", imem_req, IF_ID_valid, imem_addr);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0 || IF_ID_valid !== 1'b0) begin
      errors++;
      $display("FAIL boot_cycle: req=%b valid=%b required 0/0", imem_req, IF_ID_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b1 || currentPC !== 32'h4 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL fetch_entry: req=%b currentPC=%h addr=%h required 1/4/0", imem_req, currentPC, imem_addr);
    end
    $display("reset: boot then fetch at pc=%h", imem_addr);
  endtask

  task automatic test_straight();
    logic [31:0] pc = 32'h0;
    for (int i = 0; i < 2; i++) begin
      imem_ready = 1'b1;
      newPC      = pc + 32'd4;
      imem_data  = pc | 32'hA000_0000;
      checks++;
      if (imem_addr !== pc) begin
        errors++;
        $display("FAIL straight_addr: addr=%h required %h", imem_addr, pc);
      end
      step();
      checks++;
      if (IF_ID_PC !== pc || IF_ID_instr !== (pc | 32'hA000_0000) || IF_ID_valid !== 1'b1) begin
        errors++;
        $display("FAIL straight_ifid: pc=%h instr=%h valid=%b required %h/%h/1",
                 IF_ID_PC, IF_ID_instr, IF_ID_valid, pc, pc | 32'hA000_0000);
      end
      $display("straight: fetched pc=%h instr=%h", IF_ID_PC, IF_ID_instr);
      pc = pc + 32'd4;
    end
    checks++;
    if (imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL straight_addr3: addr=%h required 00000008", imem_addr);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1; imem_ready = 1'b1; newPC = 32'h55; imem_data = 32'hBAD0_0000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (imem_addr !== 32'h8 || IF_ID_PC !== 32'h4 || imem_req !== 1'b1 || IF_ID_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: addr=%h ifid_pc=%h req=%b valid=%b required 8/4/1/1",
                 imem_addr, IF_ID_PC, imem_req, IF_ID_valid);
      end
      $display("stall: cycle %0d addr=%h ifid_pc=%h", i, imem_addr, IF_ID_PC);
    end
    stall = 1'b0; newPC = 32'hC; imem_data = 32'hA000_0008;
    step();
    checks++;
    if (IF_ID_PC !== 32'h8 || IF_ID_instr !== 32'hA000_0008 || imem_addr !== 32'hC) begin
      errors++;
      $display("FAIL stall_release: ifid_pc=%h instr=%h addr=%h required 8/a0000008/c",
               IF_ID_PC, IF_ID_instr, imem_addr);
    end
    $display("stall release: ifid_pc=%h", IF_ID_PC);
  endtask

  task automatic test_flush();
    stall = 1'b1; flush = 1'b1; imem_ready = 1'b1; newPC = 32'h100; imem_data = 32'hDEAD_BEEF;
    step();
    checks++;
    if (imem_addr !== 32'h100 || IF_ID_valid !== 1'b0 || IF_ID_instr !== NOP || IF_ID_PC !== 32'hC) begin
      errors++;
      $display("FAIL flush: addr=%h valid=%b instr=%h ifid_pc=%h required 100/0/%h/c",
               imem_addr, IF_ID_valid, IF_ID_instr, IF_ID_PC, NOP);
    end
    $display("flush: addr=%h valid=%b", imem_addr, IF_ID_valid);
    stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_bubble();
    imem_ready = 1'b1; newPC = 32'h10; imem_data = 32'hA000_0100;
    step();
    checks++;
    if (IF_ID_PC !== 32'h100 || IF_ID_valid !== 1'b1 || imem_addr !== 32'h10) begin
      errors++;
      $display("FAIL redirect_fetch: ifid_pc=%h valid=%b addr=%h required 100/1/10",
               IF_ID_PC, IF_ID_valid, imem_addr);
    end
    imem_ready = 1'b0; newPC = 32'h999;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (IF_ID_valid !== 1'b0 || IF_ID_instr !== NOP || IF_ID_PC !== 32'h10 || imem_addr !== 32'h10) begin
        errors++;
        $display("FAIL bubble: valid=%b instr=%h ifid_pc=%h addr=%h required 0/%h/10/10",
                 IF_ID_valid, IF_ID_instr, IF_ID_PC, imem_addr, NOP);
      end
      $display("bubble: cycle %0d addr=%h", i, imem_addr);
    end
    imem_ready = 1'b1; newPC = 32'h14; imem_data = 32'hA000_0010;
    step();
    checks++;
    if (IF_ID_PC !== 32'h10 || IF_ID_valid !== 1'b1 || IF_ID_instr !== 32'hA000_0010 || imem_addr !== 32'h14) begin
      errors++;
      $display("FAIL bubble_recover: ifid_pc=%h valid=%b instr=%h addr=%h required 10/1/a0000010/14",
               IF_ID_PC, IF_ID_valid, IF_ID_instr, imem_addr);
    end
    $display("bubble recover: ifid_pc=%h", IF_ID_PC);
  endtask

  task automatic test_wrap_align();
    imem_ready = 1'b1; newPC = 32'hFFFF_FFFC; imem_data = 32'hA000_0014;
    step();
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC || currentPC !== 32'h0) begin
      errors++;
      $display("FAIL wrap: addr=%h currentPC=%h required fffffffc/0", imem_addr, currentPC);
    end
    newPC = 32'h0000_0103; imem_data = 32'hFFFF_FFFC;
    step();
    checks++;
    if (imem_addr !== 32'h100 || IF_ID_PC !== 32'hFFFF_FFFC || IF_ID_instr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL align: addr=%h ifid_pc=%h instr=%h required 100/fffffffc/fffffffc",
               imem_addr, IF_ID_PC, IF_ID_instr);
    end
    $display("wrap/align: addr=%h", imem_addr);
  endtask

`ifdef IF_PERF_CNT_EN
  task automatic test_perf();
    checks++;
    if (fetch_count !== 32'(exp_fetch) || bubble_count !== 32'(exp_bubble)) begin
      errors++;
      $display("FAIL perf_counts: fetch=%0d bubble=%0d required %0d/%0d",
               fetch_count, bubble_count, exp_fetch, exp_bubble);
    end
    $display("perf: fetch=%0d bubble=%0d", fetch_count, bubble_count);
  endtask
`endif

  task automatic test_reset_mid();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (IF_ID_valid !== 1'b0 || imem_addr !== 32'h0 || imem_req !== 1'b0 ||
        IF_ID_instr !== NOP || IF_ID_PC !== 32'h0 || currentPC !== 32'h4) begin
      errors++;
      $display("FAIL reset_mid: valid=%b addr=%h req=%b instr=%h ifid_pc=%h cpc=%h required 0/0/0/%h/0/4",
               IF_ID_valid, imem_addr, imem_req, IF_ID_instr, IF_ID_PC, currentPC, NOP);
    end
`ifdef IF_PERF_CNT_EN
    checks++;
    if (fetch_count !== 32'h0 || bubble_count !== 32'h0) begin
      errors++;
      $display("FAIL reset_counts: fetch=%0d bubble=%0d required 0/0", fetch_count, bubble_count);
    end
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_boot: req=%b required 0", imem_req);
    end
    @(posedge clk);
    #1;
    checks++;
    if (imem_req !== 1'b1 || currentPC !== 32'h4) begin
      errors++;
      $display("FAIL reset_mid_fetch: req=%b currentPC=%h required 1/4", imem_req, currentPC);
    end
    $display("mid-run reset: req=%b addr=%h", imem_req, imem_addr);
  endtask

  initial begin
    test_reset();
    test_straight();
    test_stall();
    test_flush();
    test_bubble();
    test_wrap_align();
`ifdef IF_PERF_CNT_EN
    test_perf();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
